// File: rtl/change_dispenser_if.sv
// Payout handshake bundle between the vending controller side and the change dispenser.
// The product motor drive is named prod_rel because "release" is a reserved word.
interface change_dispenser_if #(
    parameter int CNT_W = 6
);
    logic             vend;
    logic             out1;
    logic             out2;
    logic             out22;
    logic             hop_ack;
    logic             prod_ack;
    logic             refill;
    logic             prod_rel;
    logic             eject1;
    logic             eject2;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    modport master (
        output vend, out1, out2, out22, hop_ack, prod_ack, refill,
        input  prod_rel, eject1, eject2, busy, fault, cnt1, cnt2
    );

    modport slave (
        input  vend, out1, out2, out22, hop_ack, prod_ack, refill,
        output prod_rel, eject1, eject2, busy, fault, cnt1, cnt2
    );
endinterface

// File: rtl/change_dispenser.sv
// Payout back end: queues vend/coin pulses and serves them one at a time through
// motor/hopper handshakes, tracking hopper inventory and latching faults.
module change_dispenser #(
    parameter int CNT_W   = 6,
    parameter int INIT1   = 20,
    parameter int INIT2   = 20,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    change_dispenser_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL1 = CNT_W'(INIT1);
    localparam logic [CNT_W-1:0] FULL2 = CNT_W'(INIT2);

    typedef enum logic [2:0] {IDLE, PROD, COIN2, COIN1, FAULT} state_t;

    state_t           state, state_n;
    logic [2:0]       pend_prod, pend1, pend2;
    logic [2:0]       pp_n, p1_n, p2_n;
    logic [3:0]       sum_p, sum_1, sum_2;
    logic [TW-1:0]    timer, timer_n;
    logic [CNT_W-1:0] cnt1_q, cnt2_q, c1_n, c2_n;
    logic             dec_p, dec1, dec2, sub, ovf, busy_n;
    logic             rel_q, ej1_q, ej2_q, busy_q, fault_q;

    always_comb begin
        state_n = state;
        timer_n = '0;
        c1_n    = cnt1_q;
        c2_n    = cnt2_q;
        dec_p   = 1'b0;
        dec1    = 1'b0;
        dec2    = 1'b0;
        sub     = 1'b0;
        case (state)
            IDLE: begin
                if (pend_prod != '0) begin
                    state_n = PROD;
                end else if (pend2 != '0) begin
                    if (cnt2_q != '0) begin
                        state_n = COIN2;
                    end else if (cnt1_q >= CNT_W'(2)) begin
                        // 2-unit hopper empty: pay the coin as two 1-unit coins instead
                        dec2 = 1'b1;
                        sub  = 1'b1;
                    end else begin
                        state_n = FAULT;
                    end
                end else if (pend1 != '0) begin
                    state_n = (cnt1_q != '0) ? COIN1 : FAULT;
                end
            end
            PROD: begin
                if (bus.prod_ack) begin
                    dec_p   = 1'b1;
                    state_n = IDLE;
                end else if (timer == TLAST) begin
                    state_n = FAULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            COIN2: begin
                if (bus.hop_ack) begin
                    dec2    = 1'b1;
                    c2_n    = cnt2_q - 1'b1;
                    state_n = IDLE;
                end else if (timer == TLAST) begin
                    state_n = FAULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            COIN1: begin
                if (bus.hop_ack) begin
                    dec1    = 1'b1;
                    c1_n    = cnt1_q - 1'b1;
                    state_n = IDLE;
                end else if (timer == TLAST) begin
                    state_n = FAULT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: ;
        endcase

        sum_p = {1'b0, pend_prod} + {3'b000, bus.vend} - {3'b000, dec_p};
        sum_1 = {1'b0, pend1} + {3'b000, bus.out1} + {2'b00, sub, 1'b0} - {3'b000, dec1};
        sum_2 = {1'b0, pend2} + {3'b000, bus.out2} + {3'b000, bus.out22} - {3'b000, dec2};
        ovf   = (sum_p > 4'd7) || (sum_1 > 4'd7) || (sum_2 > 4'd7);

        if (state == FAULT) begin
            pp_n = pend_prod;
            p1_n = pend1;
            p2_n = pend2;
        end else begin
            pp_n = (sum_p > 4'd7) ? 3'd7 : sum_p[2:0];
            p1_n = (sum_1 > 4'd7) ? 3'd7 : sum_1[2:0];
            p2_n = (sum_2 > 4'd7) ? 3'd7 : sum_2[2:0];
            if (bus.refill) begin
                c1_n = FULL1;
                c2_n = FULL2;
            end
            if (ovf) begin
                state_n = FAULT;
            end
        end

        busy_n = (state_n != IDLE) || (pp_n != '0) || (p1_n != '0) || (p2_n != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_prod <= '0;
            pend1     <= '0;
            pend2     <= '0;
            timer     <= '0;
            cnt1_q    <= FULL1;
            cnt2_q    <= FULL2;
            rel_q     <= 1'b0;
            ej1_q     <= 1'b0;
            ej2_q     <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_n;
            pend_prod <= pp_n;
            pend1     <= p1_n;
            pend2     <= p2_n;
            timer     <= timer_n;
            cnt1_q    <= c1_n;
            cnt2_q    <= c2_n;
            rel_q     <= (state_n == PROD);
            ej1_q     <= (state_n == COIN1);
            ej2_q     <= (state_n == COIN2);
            busy_q    <= busy_n;
            fault_q   <= (state_n == FAULT);
        end
    end

    assign bus.prod_rel = rel_q;
    assign bus.eject1   = ej1_q;
    assign bus.eject2   = ej2_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
    assign bus.cnt1     = cnt1_q;
    assign bus.cnt2     = cnt2_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized checks of change_dispenser against an inventory/handshake-count model.
module tb_change_dispenser;
    localparam int CW = 6;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    change_dispenser_if #(.CNT_W(CW)) bus ();
    change_dispenser_if #(.CNT_W(CW)) bus_z ();

    change_dispenser #(.CNT_W(CW), .INIT1(20), .INIT2(20), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    change_dispenser #(.CNT_W(CW), .INIT1(20), .INIT2(0), .TIMEOUT(TO)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    always #5 clk = ~clk;

    logic hop_dir = 1'b0, prod_dir = 1'b0, hop_auto = 1'b0, prod_auto = 1'b0;
    assign bus.hop_ack  = hop_dir | hop_auto;
    assign bus.prod_ack = prod_dir | prod_auto;

    // Auto responder: acks each drive after a random 0..3 cycle delay and counts handshakes.
    logic        auto_en = 1'b0;
    int unsigned hop_seen = 0, hop_tgt = 0, prod_seen = 0, prod_tgt = 0;
    int unsigned n_prod = 0, n_e1 = 0, n_e2 = 0, overlap = 0, z_e2 = 0;
    always begin
        @(posedge clk);
        #1;
        hop_auto  = 1'b0;
        prod_auto = 1'b0;
        if ((bus.eject1 && bus.eject2) || (bus.prod_rel && (bus.eject1 || bus.eject2)))
            overlap++;
        if (bus_z.eject2) z_e2++;
        if (auto_en && (bus.eject1 || bus.eject2)) begin
            if (hop_seen == hop_tgt) begin
                hop_auto = 1'b1;
                if (bus.eject1) n_e1++;
                else n_e2++;
            end
            hop_seen++;
        end else begin
            hop_seen = 0;
            hop_tgt  = $urandom_range(0, 3);
        end
        if (auto_en && bus.prod_rel) begin
            if (prod_seen == prod_tgt) begin
                prod_auto = 1'b1;
                n_prod++;
            end
            prod_seen++;
        end else begin
            prod_seen = 0;
            prod_tgt  = $urandom_range(0, 3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic v, input logic o1, input logic o2, input logic o22);
        bus.vend = v; bus.out1 = o1; bus.out2 = o2; bus.out22 = o22;
        tick();
        bus.vend = 1'b0; bus.out1 = 1'b0; bus.out2 = 1'b0; bus.out22 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_wait", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        int unsigned c1, c2, ep, ee1, ee2;
        logic v, o1, o2, o22;
        bus.vend = 0; bus.out1 = 0; bus.out2 = 0; bus.out22 = 0; bus.refill = 0;
        bus_z.vend = 0; bus_z.out1 = 0; bus_z.out2 = 0; bus_z.out22 = 0; bus_z.refill = 0;
        bus_z.hop_ack = 0; bus_z.prod_ack = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_release", {31'b0, bus.prod_rel}, 0);
        chk("rst_eject1", {31'b0, bus.eject1}, 0);
        chk("rst_eject2", {31'b0, bus.eject2}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_fault", {31'b0, bus.fault}, 0);
        chk("rst_cnt1", 32'(bus.cnt1), 20);
        chk("rst_cnt2", 32'(bus.cnt2), 20);
        chk("z_rst_cnt2", 32'(bus_z.cnt2), 0);

        // Substitution on the empty-hopper instance
        bus_z.out2 = 1'b1; tick(); bus_z.out2 = 1'b0;
        chk("z_busy", {31'b0, bus_z.busy}, 1);
        tick();
        chk("z_sub_e1", {31'b0, bus_z.eject1}, 0);
        chk("z_sub_e2", {31'b0, bus_z.eject2}, 0);
        tick();
        chk("z_e1_a", {31'b0, bus_z.eject1}, 1);
        bus_z.hop_ack = 1'b1; tick(); bus_z.hop_ack = 1'b0;
        chk("z_e1_a_low", {31'b0, bus_z.eject1}, 0);
        chk("z_cnt1_19", 32'(bus_z.cnt1), 19);
        tick();
        chk("z_e1_b", {31'b0, bus_z.eject1}, 1);
        bus_z.hop_ack = 1'b1; tick(); bus_z.hop_ack = 1'b0;
        chk("z_cnt1_18", 32'(bus_z.cnt1), 18);
        chk("z_busy_end", {31'b0, bus_z.busy}, 0);
        chk("z_cnt2", 32'(bus_z.cnt2), 0);

        // vend + out2 + out22 together
        pulse(1, 0, 1, 1);
        chk("t1_busy", {31'b0, bus.busy}, 1);
        chk("t1_rel_lat", {31'b0, bus.prod_rel}, 0);
        tick();
        chk("t1_rel", {31'b0, bus.prod_rel}, 1);
        tick(); tick(); tick();
        chk("t1_rel_hold", {31'b0, bus.prod_rel}, 1);
        chk("t1_e2_wait", {31'b0, bus.eject2}, 0);
        prod_dir = 1'b1; tick(); prod_dir = 1'b0;
        chk("t1_gap_rel", {31'b0, bus.prod_rel}, 0);
        chk("t1_gap_e2", {31'b0, bus.eject2}, 0);
        tick();
        chk("t1_e2_a", {31'b0, bus.eject2}, 1);
        hop_dir = 1'b1; tick(); hop_dir = 1'b0;
        chk("t1_gap2", {31'b0, bus.eject2}, 0);
        chk("t1_cnt2_19", 32'(bus.cnt2), 19);
        tick();
        chk("t1_e2_b", {31'b0, bus.eject2}, 1);
        hop_dir = 1'b1; tick(); hop_dir = 1'b0;
        chk("t1_cnt2_18", 32'(bus.cnt2), 18);
        chk("t1_busy_end", {31'b0, bus.busy}, 0);

        // out1 arriving together with a stray hop_ack
        bus.out1 = 1'b1; hop_dir = 1'b1; tick(); bus.out1 = 1'b0; hop_dir = 1'b0;
        chk("t2_ack_ignored", 32'(bus.cnt1), 20);
        chk("t2_e1_lat", {31'b0, bus.eject1}, 0);
        tick();
        chk("t2_e1", {31'b0, bus.eject1}, 1);
        tick();
        chk("t2_e1_hold", {31'b0, bus.eject1}, 1);
        hop_dir = 1'b1; tick(); hop_dir = 1'b0;
        chk("t2_e1_low", {31'b0, bus.eject1}, 0);
        chk("t2_cnt1", 32'(bus.cnt1), 19);
        chk("t2_busy", {31'b0, bus.busy}, 0);

        // Pending overflow while the product motor is stalled
        pulse(1, 0, 0, 0);
        tick();
        chk("t4_rel", {31'b0, bus.prod_rel}, 1);
        for (int i = 1; i <= 8; i++) begin
            pulse(0, 1, 0, 0);
            if (i == 7) chk("t4_no_fault_7", {31'b0, bus.fault}, 0);
        end
        chk("t4_fault_8", {31'b0, bus.fault}, 1);
        chk("t4_rel_low", {31'b0, bus.prod_rel}, 0);
        chk("t4_busy", {31'b0, bus.busy}, 1);
        do_reset();

        // Hopper timeout
        pulse(0, 1, 0, 0);
        tick();
        cnt = 0;
        for (int i = 0; i < 300 && bus.eject1; i++) begin
            cnt++;
            tick();
        end
        chk("t5_timeout_len", cnt, TO);
        chk("t5_fault", {31'b0, bus.fault}, 1);
        chk("t5_e1_low", {31'b0, bus.eject1}, 0);
        pulse(0, 1, 0, 0);
        tick();
        chk("t5_fault_sticky", {31'b0, bus.fault}, 1);
        chk("t5_e1_still_low", {31'b0, bus.eject1}, 0);
        chk("t5_cnt1_frozen", 32'(bus.cnt1), 20);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_fault", {31'b0, bus.fault}, 0);
        chk("t5_rst_busy", {31'b0, bus.busy}, 0);
        rst = 1'b0;
        tick();

        // Drain the 2-unit hopper to 5, then refill during the ack cycle
        auto_en = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < ((b == 2) ? 1 : 7); k++) pulse(0, 0, 1, 0);
            wait_idle(200);
        end
        auto_en = 1'b0;
        tick();
        chk("t6_cnt2_5", 32'(bus.cnt2), 5);
        pulse(0, 0, 1, 0);
        tick();
        chk("t6_e2", {31'b0, bus.eject2}, 1);
        hop_dir = 1'b1; bus.refill = 1'b1; tick(); hop_dir = 1'b0; bus.refill = 1'b0;
        chk("t6_cnt2_refill", 32'(bus.cnt2), 20);
        chk("t6_e2_low", {31'b0, bus.eject2}, 0);
        chk("t6_busy", {31'b0, bus.busy}, 0);

        // Asynchronous reset in the middle of a dispense
        pulse(1, 0, 0, 0);
        tick();
        chk("t7_rel", {31'b0, bus.prod_rel}, 1);
        #2 rst = 1'b1;
        #1;
        chk("t7_rel_async", {31'b0, bus.prod_rel}, 0);
        chk("t7_busy_async", {31'b0, bus.busy}, 0);
        rst = 1'b0;
        tick();

        // Random batches against the inventory / handshake-count model
        n_prod = 0; n_e1 = 0; n_e2 = 0;
        c1 = 20; c2 = 20; ep = 0; ee1 = 0; ee2 = 0;
        auto_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            if (c1 < 6) begin
                bus.refill = 1'b1; tick(); bus.refill = 1'b0;
                c1 = 20; c2 = 20;
                chk("rnd_refill_cnt1", 32'(bus.cnt1), c1);
            end
            v = 1'($urandom_range(0, 1));
            o1 = 1'($urandom_range(0, 1));
            o2 = 1'($urandom_range(0, 1));
            o22 = 1'($urandom_range(0, 1));
            pulse(v, o1, o2, o22);
            ep += v;
            for (int k = 0; k < int'(o2) + int'(o22); k++) begin
                if (c2 > 0) begin
                    c2--; ee2++;
                end else begin
                    c1 -= 2; ee1 += 2;
                end
            end
            if (o1) begin
                c1--; ee1++;
            end
            wait_idle(200);
            chk("rnd_cnt1", 32'(bus.cnt1), c1);
            chk("rnd_cnt2", 32'(bus.cnt2), c2);
            chk("rnd_fault", {31'b0, bus.fault}, 0);
        end
        auto_en = 1'b0;
        tick();
        chk("rnd_prod_count", n_prod, ep);
        chk("rnd_e1_count", n_e1, ee1);
        chk("rnd_e2_count", n_e2, ee2);
        chk("drive_overlap", overlap, 0);
        chk("z_never_e2", z_e2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
